// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg
//   Shared types and constants for the instruction-ROM access arbiter.
//   - state_t : arbiter FSM states (IDLE, BUSY)
//   - owner_t : which requester owns the outstanding transaction
//   - ROM_LATENCY_MAX / CNT_W : widest supported ROM latency and the
//     latency counter width derived from it
package rom_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DEBUG = 1'b1
  } owner_t;

  localparam int ROM_LATENCY_MAX = 3;
  localparam int CNT_W           = $clog2(ROM_LATENCY_MAX + 1);

endpackage

// File: rtl/rom_arb_picker.sv
// rom_arb_picker
//   Chooses the winner among the eligible requesters.
//   Build option ROM_ARB_RR_EN:
//     defined   - round-robin on ties, using a last-winner register that
//                 resets to OWN_DEBUG (so Fetch wins the first tie)
//     undefined - fixed priority, Fetch over Debug; purely combinational
// Ports:
//   i_clk, i_rst, i_take  (ROM_ARB_RR_EN only) clock, async reset, grant strobe
//   i_elig[1:0]           eligible requests, bit0 = Fetch, bit1 = Debug
//   o_any                 at least one request is eligible
//   o_winner              selected owner (meaningful only when o_any)
module rom_arb_picker
  import rom_arb_pkg::*;
(
`ifdef ROM_ARB_RR_EN
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_take,
`endif
  input  logic [1:0] i_elig,
  output logic       o_any,
  output owner_t     o_winner
);

  assign o_any = |i_elig;

`ifdef ROM_ARB_RR_EN
  owner_t r_last_winner;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_winner <= OWN_DEBUG;
    end else if (i_take) begin
      r_last_winner <= o_winner;
    end
  end

  always_comb begin
    o_winner = OWN_FETCH;
    if (i_elig == 2'b11) begin
      // tie: the port that did not win last time goes first
      o_winner = (r_last_winner == OWN_FETCH) ? OWN_DEBUG : OWN_FETCH;
    end else if (i_elig[1]) begin
      o_winner = OWN_DEBUG;
    end
  end
`else
  always_comb begin
    o_winner = OWN_FETCH;
    if (!i_elig[0] && i_elig[1]) begin
      o_winner = OWN_DEBUG;
    end
  end
`endif

endmodule

// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter
//   Shares one synchronous instruction ROM between the processor fetch port
//   and the debug (hex display) read port. One read is outstanding at a time;
//   the word is returned to whichever port issued it.
//   Build option ROM_ARB_RR_EN selects round-robin instead of fixed priority.
// Ports:
//   clk_27, Reset                    clock, async active-high reset
//   Fetch_Req/Address/Flush          fetch request, address, cancel
//   Fetch_Grant/Valid/Data           grant pulse, data pulse, last fetch word
//   Debug_Req/Address                debug request, address
//   Debug_Grant/Valid/Data           grant pulse, data pulse, last debug word
//   ROM_Address_Select, ROM_Read     to ROM address / clken
//   ROM_Out                          from ROM q
//   Busy                             a transaction is outstanding
module rom_access_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ROM_LATENCY = 1
) (
  input  logic              clk_27,
  input  logic              Reset,
  input  logic              Fetch_Req,
  input  logic [ADDR_W-1:0] Fetch_Address,
  input  logic              Fetch_Flush,
  output logic              Fetch_Grant,
  output logic              Fetch_Valid,
  output logic [DATA_W-1:0] Fetch_Data,
  input  logic              Debug_Req,
  input  logic [ADDR_W-1:0] Debug_Address,
  output logic              Debug_Grant,
  output logic              Debug_Valid,
  output logic [DATA_W-1:0] Debug_Data,
  output logic [ADDR_W-1:0] ROM_Address_Select,
  output logic              ROM_Read,
  input  logic [DATA_W-1:0] ROM_Out,
  output logic              Busy
);

  if (ROM_LATENCY < 1 || ROM_LATENCY > ROM_LATENCY_MAX) begin : g_bad_latency
    $error("rom_access_arbiter: ROM_LATENCY=%0d outside 1..%0d",
           ROM_LATENCY, ROM_LATENCY_MAX);
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ROM_LATENCY);

  state_t            r_state;
  owner_t            r_owner;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_cancel;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_rom_read;
  logic              r_busy;
  logic              r_fetch_grant;
  logic              r_fetch_valid;
  logic [DATA_W-1:0] r_fetch_data;
  logic              r_debug_grant;
  logic              r_debug_valid;
  logic [DATA_W-1:0] r_debug_data;

  logic [1:0]        w_elig;
  logic              w_any;
  owner_t            w_winner;
  logic              w_take;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_flush_hit;

  // a flushed fetch is not eligible in that cycle
  assign w_elig     = {Debug_Req, Fetch_Req & ~Fetch_Flush};
  assign w_take     = (r_state == IDLE) && w_any;
  assign w_sel_addr = (w_winner == OWN_FETCH) ? Fetch_Address : Debug_Address;
  // flush on the completing edge also cancels, so no BUSY cycle is missed
  assign w_flush_hit = r_cancel || Fetch_Flush;

  rom_arb_picker u_picker (
`ifdef ROM_ARB_RR_EN
    .i_clk    (clk_27),
    .i_rst    (Reset),
    .i_take   (w_take),
`endif
    .i_elig   (w_elig),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

  always_ff @(posedge clk_27 or posedge Reset) begin
    if (Reset) begin
      r_state       <= IDLE;
      r_owner       <= OWN_FETCH;
      r_cnt         <= '0;
      r_cancel      <= 1'b0;
      r_rom_addr    <= '0;
      r_rom_read    <= 1'b0;
      r_busy        <= 1'b0;
      r_fetch_grant <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_fetch_data  <= '0;
      r_debug_grant <= 1'b0;
      r_debug_valid <= 1'b0;
      r_debug_data  <= '0;
    end else begin
      r_fetch_grant <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_debug_grant <= 1'b0;
      r_debug_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_owner       <= w_winner;
            r_rom_addr    <= w_sel_addr;
            r_fetch_grant <= (w_winner == OWN_FETCH);
            r_debug_grant <= (w_winner == OWN_DEBUG);
            r_rom_read    <= 1'b1;
            r_busy        <= 1'b1;
            r_cnt         <= CNT_LOAD;
            r_state       <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_owner == OWN_FETCH && Fetch_Flush) begin
              r_cancel <= 1'b1;
            end
          end else begin
            if (r_owner == OWN_DEBUG) begin
              r_debug_data  <= ROM_Out;
              r_debug_valid <= 1'b1;
            end else if (!w_flush_hit) begin
              r_fetch_data  <= ROM_Out;
              r_fetch_valid <= 1'b1;
            end
            r_rom_read <= 1'b0;
            r_busy     <= 1'b0;
            r_cancel   <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Fetch_Grant        = r_fetch_grant;
  assign Fetch_Valid        = r_fetch_valid;
  assign Fetch_Data         = r_fetch_data;
  assign Debug_Grant        = r_debug_grant;
  assign Debug_Valid        = r_debug_valid;
  assign Debug_Data         = r_debug_data;
  assign ROM_Address_Select = r_rom_addr;
  assign ROM_Read           = r_rom_read;
  assign Busy               = r_busy;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// tb_rom_access_arbiter
//   Three arbiter instances with ROM_LATENCY 1, 2, 3, each with a ROM model
//   returning address ^ 32'hA5A5A5A5 after L clken-sampled edges.
module tb_rom_access_arbiter;
  localparam int NI = 3;
  localparam logic [31:0] XK = 32'hA5A5A5A5;

  typedef struct {
    int          port;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NI-1:0]       fq, ff, dq;
  logic [NI-1:0][31:0] fa, da;
  logic [NI-1:0]       fg, fv, dg, dv, rd, bz;
  logic [NI-1:0][31:0] fd, dd, ra, rq;

  exp_t sb[$];
  int   glog[$];
  int   gcyc[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   nvalid   = 0;
  int   cyc      = 0;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int L = k + 1;
    logic [31:0] pipe [L];

    rom_access_arbiter #(
      .ADDR_W(32), .DATA_W(32), .ROM_LATENCY(L)
    ) u_dut (
      .clk_27             (clk),
      .Reset              (rst),
      .Fetch_Req          (fq[k]),
      .Fetch_Address      (fa[k]),
      .Fetch_Flush        (ff[k]),
      .Fetch_Grant        (fg[k]),
      .Fetch_Valid        (fv[k]),
      .Fetch_Data         (fd[k]),
      .Debug_Req          (dq[k]),
      .Debug_Address      (da[k]),
      .Debug_Grant        (dg[k]),
      .Debug_Valid        (dv[k]),
      .Debug_Data         (dd[k]),
      .ROM_Address_Select (ra[k]),
      .ROM_Read           (rd[k]),
      .ROM_Out            (rq[k]),
      .Busy               (bz[k])
    );

    always @(posedge clk) begin
      if (rd[k]) begin
        pipe[0] <= ra[k] ^ XK;
        for (int s = 1; s < L; s++) pipe[s] <= pipe[s-1];
      end
    end
    assign rq[k] = pipe[L-1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_valid(input int port, input logic [31:0] data);
    exp_t e;
    nvalid++;
    chk("sb_has_entry", 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_port", port, e.port);
      chk("sb_data", data, e.data);
    end
  endtask

  task automatic tick(input int k);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (fg[k]) begin glog.push_back(0); gcyc.push_back(cyc); end
    if (dg[k]) begin glog.push_back(1); gcyc.push_back(cyc); end
    if (fv[k]) check_valid(0, fd[k]);
    if (dv[k]) check_valid(1, dd[k]);
  endtask

  task automatic drain(input int k, input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick(k);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  // single isolated transaction: checks grant, address, ROM_Read hold and L+1 latency
  task automatic run_txn(input int k, input int port, input logic [31:0] addr);
    int n = 0;
    int nv0;
    if (port == 0) begin fa[k] = addr; fq[k] = 1'b1; end
    else begin da[k] = addr; dq[k] = 1'b1; end
    sb.push_back('{port: port, data: addr ^ XK});
    nv0 = nvalid;
    tick(k);
    chk("txn_grant", (port == 0) ? fg[k] : dg[k], 1);
    chk("txn_addr", ra[k], addr);
    fq[k] = 1'b0;
    dq[k] = 1'b0;
    while (nvalid == nv0 && n < 12) begin
      chk("txn_read_hold", rd[k], 1);
      tick(k);
      n++;
    end
    chk("txn_latency", n, k + 2);
    chk("txn_read_clr", rd[k], 0);
    chk("txn_busy_clr", bz[k], 0);
  endtask

  initial begin
    int exp_ord[4];
    int n;
    fq = '0; ff = '0; dq = '0; fa = '0; da = '0;

    // reset state
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_flags", {26'd0, fg[k], fv[k], dg[k], dv[k], rd[k], bz[k]}, 0);
      chk("rst_fdata", fd[k], 0);
      chk("rst_ddata", dd[k], 0);
      chk("rst_addr", ra[k], 0);
    end
    rst = 1'b0;

    // reset mid-BUSY, L=3, debug read of 0x20
    da[2] = 32'h20; dq[2] = 1'b1;
    tick(2);
    chk("mid_dgrant", dg[2], 1);
    chk("mid_busy", bz[2], 1);
    chk("mid_read", rd[2], 1);
    chk("mid_addr", ra[2], 32'h20);
    dq[2] = 1'b0;
    tick(2);
    tick(2);
    chk("mid_busy2", bz[2], 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_flags", {26'd0, fg[2], fv[2], dg[2], dv[2], rd[2], bz[2]}, 0);
    chk("mid_rst_addr", ra[2], 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(2);
      chk("mid_no_dvalid", dv[2], 0);
    end
    chk("mid_ddata", dd[2], 0);
    run_txn(2, 0, 32'h0);
    chk("post_rst_fdata", fd[2], 32'hA5A5A5A5);

    // contention, L=1: Fetch 0x4 first, then Debug 0x8 granted at edge L+2
    fa[0] = 32'h4; da[0] = 32'h8; fq[0] = 1'b1; dq[0] = 1'b1;
    sb.push_back('{port: 0, data: 32'hA5A5A5A1});
    sb.push_back('{port: 1, data: 32'hA5A5A5AD});
    tick(0);
    chk("cont_fgrant", fg[0], 1);
    chk("cont_dgrant0", dg[0], 0);
    fq[0] = 1'b0;
    tick(0);
    chk("cont_dgrant1", dg[0], 0);
    tick(0);
    chk("cont_dgrant2", dg[0], 0);
    tick(0);
    chk("cont_dgrant3", dg[0], 1);
    chk("cont_daddr", ra[0], 32'h8);
    dq[0] = 1'b0;
    drain(0, 10);

    // single fetch, L=1, 0x10
    fa[0] = 32'h10; fq[0] = 1'b1;
    sb.push_back('{port: 0, data: 32'hA5A5A5B5});
    tick(0);
    chk("sf_grant", fg[0], 1);
    chk("sf_read0", rd[0], 1);
    fq[0] = 1'b0;
    tick(0);
    chk("sf_grant_off", fg[0], 0);
    chk("sf_read1", rd[0], 1);
    chk("sf_valid1", fv[0], 0);
    tick(0);
    chk("sf_valid2", fv[0], 1);
    chk("sf_data", fd[0], 32'hA5A5A5B5);
    chk("sf_read2", rd[0], 0);
    tick(0);
    chk("sf_valid_pulse", fv[0], 0);
    chk("sf_data_hold", fd[0], 32'hA5A5A5B5);

    // both held for four transactions, L=2
`ifdef ROM_ARB_RR_EN
    exp_ord = '{0, 1, 0, 1};
`else
    exp_ord = '{0, 0, 0, 0};
`endif
    glog.delete();
    gcyc.delete();
    fa[1] = 32'h40; da[1] = 32'h44; fq[1] = 1'b1; dq[1] = 1'b1;
    for (int i = 0; i < 4; i++)
      sb.push_back('{port: exp_ord[i], data: ((exp_ord[i] == 0) ? 32'h40 : 32'h44) ^ XK});
    n = 0;
    while (glog.size() < 4 && n < 40) begin
      tick(1);
      n++;
    end
    fq[1] = 1'b0; dq[1] = 1'b0;
    drain(1, 20);
    chk("hold_ngrants", glog.size(), 4);
    for (int i = 0; i < glog.size() && i < 4; i++) chk("hold_order", glog[i], exp_ord[i]);
    for (int i = 1; i < gcyc.size(); i++) chk("hold_period", gcyc[i] - gcyc[i-1], 4);

    // flush in BUSY, L=2
    run_txn(1, 0, 32'h34);
    fa[1] = 32'h30; fq[1] = 1'b1;
    tick(1);
    chk("fl_grant", fg[1], 1);
    fq[1] = 1'b0;
    ff[1] = 1'b1;
    tick(1);
    ff[1] = 1'b0;
    chk("fl_busy1", bz[1], 1);
    tick(1);
    chk("fl_busy2", bz[1], 1);
    tick(1);
    chk("fl_busy3", bz[1], 0);
    chk("fl_valid3", fv[1], 0);
    chk("fl_read3", rd[1], 0);
    tick(1);
    chk("fl_valid4", fv[1], 0);
    chk("fl_data", fd[1], 32'h34 ^ XK);

    // flush in IDLE: debug wins, fetch not granted
    ff[1] = 1'b1; fq[1] = 1'b1; fa[1] = 32'h50;
    dq[1] = 1'b1; da[1] = 32'h54;
    sb.push_back('{port: 1, data: 32'h54 ^ XK});
    tick(1);
    chk("fi_dgrant", dg[1], 1);
    chk("fi_fgrant", fg[1], 0);
    chk("fi_addr", ra[1], 32'h54);
    ff[1] = 1'b0; fq[1] = 1'b0; dq[1] = 1'b0;
    drain(1, 10);
    chk("fi_fdata", fd[1], 32'h34 ^ XK);

    // plain debug read, L=3
    run_txn(2, 1, 32'h3C);
    chk("dbg_data", dd[2], 32'h3C ^ XK);

    chk("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rom_access_arbiter.md
# rom_access_arbiter

Shares the single synchronous instruction ROM between two requesters: the processor's instruction-fetch port and a debug read port that feeds the hex display. It owns the ROM's `address`/`clken` inputs, sequences one read at a time through the ROM's fixed output latency, and returns the word to the requester that issued it. It sits between `Processor`/debug logic and `InstructionROM`, replacing the direct `ROM_Address_Select`/`ROM_Read` connection.

## Interface
Parameters:
- `ADDR_W`, 32: ROM address width.
- `DATA_W`, 32: ROM word width.
- `ROM_LATENCY`, 1: edges from the first `clken`-high sampling edge until `ROM_Out` is valid. Legal range is 1–3; any other value is an elaboration error.

Ports:
- `clk_27`  in  1: sole clock, rising edge.
- `Reset`  in  1: asynchronous, active-high.
- `Fetch_Req`  in  1: fetch request (level).
- `Fetch_Address`  in  ADDR_W: fetch address, valid while `Fetch_Req` is high.
- `Fetch_Flush`  in  1: cancels the fetch (PC reset/branch).
- `Fetch_Grant`  out  1: one-cycle pulse, fetch address accepted.
- `Fetch_Valid`  out  1: one-cycle pulse, `Fetch_Data` updated.
- `Fetch_Data`  out  DATA_W: last completed fetch word.
- `Debug_Req`, `Debug_Address`, `Debug_Grant`, `Debug_Valid`, `Debug_Data`: same meaning for the debug port. There is no flush on this port.
- `ROM_Address_Select`  out  ADDR_W: to ROM `address`.
- `ROM_Read`  out  1: to ROM `clken`.
- `ROM_Out`  in  DATA_W: from ROM `q`.
- `Busy`  out  1: a transaction is outstanding.

## Operation
- Two states: `IDLE` and `BUSY`. Only one transaction is outstanding at a time.
- **IDLE**
  - Requests are sampled only in this state.
  - If any request is eligible, the arbiter picks a winner and latches the owner and its address into `ROM_Address_Select`.
  - It then pulses the winner's Grant, sets `ROM_Read`=1, sets `Busy`=1, loads `cnt`=`ROM_LATENCY`, and moves to `BUSY`.
  - A fetch is not eligible in any cycle where `Fetch_Flush` is high.
- **BUSY**
  - `ROM_Read` and `ROM_Address_Select` are held stable.
  - `cnt` decrements on each edge while nonzero.
  - On the edge where `cnt`==0: capture `ROM_Out` into the owner's Data register, pulse the owner's Valid, clear `ROM_Read`/`Busy`, and return to `IDLE`.
- **Flush**
  - If `Fetch_Flush` is high on any BUSY cycle while the owner is Fetch, a sticky `cancel` flag sets.
  - At completion with `cancel` set, `Fetch_Valid` stays 0 and `Fetch_Data` is unchanged. The flag clears on the return to `IDLE`.
  - `Fetch_Flush` has no effect on a transaction owned by Debug.
- **Request rules**
  - Req is a level. The requester holds Req and Address until Grant, and may drop them in the Grant cycle.
  - A Req still high when the arbiter is next in `IDLE` is a new request.
- **Arbitration (default)**
  - Fixed priority, Fetch over Debug. Debug may starve; this is accepted.
- **Data registers**
  - Each port's Data register holds its last completed value indefinitely.
- **Reset values**
  - All outputs are 0, state is `IDLE`, `cnt`=0, `cancel`=0, and the last-winner flag is Debug.
  - Reset asserted mid-`BUSY` aborts immediately. No Valid is produced, and the ROM's stale output is never captured.

## Timing
- A request sampled at edge 0 gives Grant high after edge 0 and `ROM_Read` high after edges 0…L (L = `ROM_LATENCY`).
- Data is captured and Valid goes high after edge L+1.
- Latency from the Req-sampling edge to Valid is L+1 edges.
- The next request is sampled at edge L+2, so peak throughput is one word per L+2 cycles.
- Grant and Valid are never high together for one port. They can be high in the same cycle only for different ports, and only for L≥1 with back-to-back traffic, which is impossible here because Grant is issued only from `IDLE`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `ROM_ARB_RR_EN` defined:
  - Round-robin arbitration. When both requests are eligible, the port that was not the most recent winner wins.
  - The last-winner flag updates on every Grant. It resets to Debug, so Fetch wins the first tie.
  - A single eligible request always wins.
- Undefined: fixed priority (Fetch first), and the last-winner register is not built.

## Structure
- Package `rom_arb_pkg` contains:
  - The state enum (`IDLE`, `BUSY`).
  - The owner encoding (`OWN_FETCH`=0, `OWN_DEBUG`=1).
  - `ROM_LATENCY_MAX`=3.
  - The `cnt` width, derived from `ROM_LATENCY_MAX`.
- One sub-module, `rom_arb_picker`:
  - Takes the eligible-request vector and returns the winner.
  - Contains the last-winner register under `ROM_ARB_RR_EN`.
  - Is purely combinational when the macro is undefined.

## Test plan
The ROM model returns `q` = address XOR 0xA5A5A5A5, with latency L.
- **Reset:** assert Reset mid-`BUSY` (L=3, Debug read of 0x20) → every output is 0 immediately. No `Debug_Valid` follows. A fresh fetch of 0x0 afterwards completes normally.
- **Single fetch:** L=1, `Fetch_Req` with 0x10 sampled at edge 0 → `Fetch_Grant` after edge 0, `ROM_Read` high for edges 0–1, `Fetch_Valid` after edge 2 with `Fetch_Data`=0xA5A5A5B5.
- **Contention, fixed priority:** Fetch 0x4 and Debug 0x8 both held high → Fetch completes first (0xA5A5A5A1), then Debug (0xA5A5A5AD) is granted at edge L+2.
- **Contention, `ROM_ARB_RR_EN`:** both requests held continuously for four transactions → grants go Fetch, Debug, Fetch, Debug.
- **Flush:** L=2, fetch of 0x30 granted, then `Fetch_Flush` pulses for one cycle in `BUSY` → `Busy` clears on schedule, `Fetch_Valid` never pulses, `Fetch_Data` keeps its prior value.
- **Flush in IDLE:** `Fetch_Flush` and `Fetch_Req` are high together in `IDLE` while `Debug_Req` is high → Debug is granted that edge and Fetch is not.
